// File: rtl/grid_frame_sched_if.sv
// Pixel stream from the frame scheduler to the LCD writer.
// One transfer per cycle where valid & ready; first/last mark frame boundaries.
interface grid_frame_sched_if;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        first;
  logic        last;

  modport master (output data, valid, first, last, input ready);
  modport slave  (input data, valid, first, last, output ready);
endinterface

// File: rtl/grid_frame_sched.sv
// Frame scheduler: freezes the board rows, sweeps the screen through the grid
// renderer and streams the returned RGB565 pixels out over valid/ready.
module grid_frame_sched #(
  parameter int SCR_W = 128,
  parameter int SCR_H = 160,
  parameter int ROW_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_req,
  input  logic [ROW_W-1:0] row_in_0,
  input  logic [ROW_W-1:0] row_in_1,
  input  logic [ROW_W-1:0] row_in_2,
  input  logic [ROW_W-1:0] row_in_3,
  input  logic [ROW_W-1:0] row_in_4,
  input  logic [ROW_W-1:0] row_in_5,
  input  logic [ROW_W-1:0] row_in_6,
  input  logic [ROW_W-1:0] row_in_7,
  output logic [ROW_W-1:0] row_out_0,
  output logic [ROW_W-1:0] row_out_1,
  output logic [ROW_W-1:0] row_out_2,
  output logic [ROW_W-1:0] row_out_3,
  output logic [ROW_W-1:0] row_out_4,
  output logic [ROW_W-1:0] row_out_5,
  output logic [ROW_W-1:0] row_out_6,
  output logic [ROW_W-1:0] row_out_7,
  output logic [7:0]       ram_addr_x,
  output logic [7:0]       ram_addr_y,
  input  logic [15:0]      ram_data,
  grid_frame_sched_if.master pix,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCR_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_STREAM, S_DONE} state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } pix_t;

  state_e                 state_q, state_d;
  logic [7:0]             x_q, x_d, y_q, y_d;
  logic                   all_iss_q, all_iss_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   rd_first_q, rd_first_d;
  logic                   rd_last_q, rd_last_d;
  pix_t                   out_q, out_d, skid_q, skid_d;
  logic                   out_vld_q, out_vld_d;
  logic                   skid_vld_q, skid_vld_d;
  logic                   pend_q, pend_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0][ROW_W-1:0]  rows_q, rows_d, rows_in;

  logic hs, out_free, iss, at_last;
  pix_t rd_pix;

  assign rows_in = {row_in_7, row_in_6, row_in_5, row_in_4,
                    row_in_3, row_in_2, row_in_1, row_in_0};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    all_iss_d  = all_iss_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    pend_d     = pend_q;
    rows_d     = rows_q;

    hs       = out_vld_q & pix.ready;
    out_free = ~out_vld_q | pix.ready;
    rd_pix   = '{data: ram_data, first: rd_first_q, last: rd_last_q};

    // Skid drains into the output register before the in-flight read does.
    if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = rd_vld_q;
        if (rd_vld_q) skid_d = rd_pix;
      end else begin
        out_vld_d = rd_vld_q;
        if (rd_vld_q) out_d = rd_pix;
      end
    end else if (rd_vld_q) begin
      skid_vld_d = 1'b1;
      skid_d     = rd_pix;
    end

    // Issuing only when the skid stays empty leaves room for the read that
    // lands next cycle even if the writer stalls then.
    at_last    = (x_q == X_LAST) && (y_q == Y_LAST);
    iss        = (state_q == S_STREAM) && !all_iss_q && !skid_vld_d;
    rd_vld_d   = iss;
    rd_first_d = iss && (x_q == 8'd0) && (y_q == 8'd0);
    rd_last_d  = iss && at_last;
    if (iss) begin
      if (at_last) begin
        all_iss_d = 1'b1;
      end else if (x_q == X_LAST) begin
        x_d = 8'd0;
        y_d = y_q + 8'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (frame_req || pend_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        rows_d    = rows_in;
        x_d       = 8'd0;
        y_d       = 8'd0;
        all_iss_d = 1'b0;
        pend_d    = 1'b0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (frame_req) pend_d = 1'b1;
        if (hs && out_q.last) state_d = S_DONE;
      end
      S_DONE: begin
        pend_d = pend_q | frame_req;
        if (frame_req || pend_q) state_d = S_LATCH;
        else                     state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LATCH) || (state_d == S_STREAM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      all_iss_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rows_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      all_iss_q  <= all_iss_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rows_q     <= rows_d;
    end
  end

  assign ram_addr_x = x_q;
  assign ram_addr_y = y_q;
  assign pix.data   = out_q.data;
  assign pix.valid  = out_vld_q;
  assign pix.first  = out_vld_q & out_q.first;
  assign pix.last   = out_vld_q & out_q.last;
  assign busy       = busy_q;
  assign frame_done = done_q;

  assign row_out_0 = rows_q[0];
  assign row_out_1 = rows_q[1];
  assign row_out_2 = rows_q[2];
  assign row_out_3 = rows_q[3];
  assign row_out_4 = rows_q[4];
  assign row_out_5 = rows_q[5];
  assign row_out_6 = rows_q[6];
  assign row_out_7 = rows_q[7];

endmodule

// File: tb/tb_grid_frame_sched.sv
// Directed bench for grid_frame_sched: renderer model returns {y,x}, each
// handshaked pixel is checked against the expected row-major scan position.
module tb_grid_frame_sched;

  localparam int NPIX = 128 * 160;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  frame_req = 1'b0;
  logic [7:0][39:0]      ri = '0;
  logic [7:0][39:0]      ro;
  logic [7:0]            ax, ay;
  logic [15:0]           ram_data = '0;
  logic                  busy, frame_done;
  int                    total = 0;
  int                    bad = 0;
  int                    fd_cnt = 0;

  grid_frame_sched_if pif ();

  grid_frame_sched dut (
    .clk(clk), .rst(rst), .frame_req(frame_req),
    .row_in_0(ri[0]), .row_in_1(ri[1]), .row_in_2(ri[2]), .row_in_3(ri[3]),
    .row_in_4(ri[4]), .row_in_5(ri[5]), .row_in_6(ri[6]), .row_in_7(ri[7]),
    .row_out_0(ro[0]), .row_out_1(ro[1]), .row_out_2(ro[2]), .row_out_3(ro[3]),
    .row_out_4(ro[4]), .row_out_5(ro[5]), .row_out_6(ro[6]), .row_out_7(ro[7]),
    .ram_addr_x(ax), .ram_addr_y(ay), .ram_data(ram_data),
    .pix(pif), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Registered renderer: pixel value encodes its own address.
  always @(posedge clk) ram_data <= {ay, ax};

  always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered on the negedge where the request (or pending) is already in place.
  task automatic run_frame(input int lowpct, input int abort_at,
                           input int req_a, input int req_b, input int row_chg);
    int          hs, cyc, first_v, first_hs, last_hs;
    logic [7:0]  ex, ey;
    logic        held, snap_ok;
    logic [15:0] held_data;
    logic [39:0] snap;
    hs = 0; cyc = 0; first_v = -1; first_hs = -1; last_hs = -1;
    ex = 0; ey = 0; held = 0; held_data = 0; snap_ok = 1; snap = ri[0];
    @(negedge clk); cyc = 1; frame_req = 0;
    chk("busy_in_latch", busy, 1);
    chk("no_valid_in_latch", pif.valid, 0);
    forever begin
      if (hs == abort_at) begin
        rst = 0;
        #1;
        chk("abort_valid", pif.valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_addr", {ay, ax}, 0);
        chk("abort_row0", ro[0], 0);
        chk("abort_done", frame_done, 0);
        return;
      end
      pif.ready = (int'($urandom_range(99)) >= lowpct);
      if (cyc >= 2 && ro[0] !== snap) snap_ok = 0;
      if (held) chk("stall_hold", {pif.valid, pif.data}, {1'b1, held_data});
      if (pif.valid && first_v < 0) first_v = cyc;
      if (pif.valid && pif.ready) begin
        chk("pix_data", pif.data, {ey, ex});
        chk("pix_first", pif.first, hs == 0);
        chk("pix_last", pif.last, hs == NPIX - 1);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (ex == 8'd127) begin ex = 0; ey = ey + 8'd1; end
        else ex = ex + 8'd1;
        hs++;
        if (hs == req_a || hs == req_b) frame_req = 1;
        if (hs == row_chg) ri[0] = '0;
      end
      held = pif.valid && !pif.ready;
      held_data = pif.data;
      if (hs == NPIX || cyc >= 50000) break;
      @(negedge clk); cyc++; frame_req = 0;
    end
    chk("hs_count", hs, NPIX);
    chk("first_latency", first_v, 4);
    if (lowpct == 0) chk("throughput", last_hs - first_hs, NPIX - 1);
    chk("snapshot_row0", snap_ok, 1);
    @(negedge clk); frame_req = 0;
    chk("frame_done_pulse", frame_done, 1);
    chk("valid_after_last", pif.valid, 0);
    chk("busy_after_last", busy, 0);
  endtask

  initial begin
    pif.ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", pif.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_addr", {ay, ax}, 0);
    chk("rst_row0", ro[0], 0);
    chk("rst_row7", ro[7], 0);

    rst = 1;
    ri[0] = 40'h0000000010;
    for (int k = 1; k < 8; k++) ri[k] = {k[7:0], 32'hC0DE0000};
    @(negedge clk);
    frame_req = 1;
    // Full-rate frame with requests at pixel 10/20 and row change at 100.
    run_frame(0, -1, 10, 20, 100);
    chk("row7_snap", ro[7], {8'd7, 32'hC0DE0000});
    // Pending frame starts from DONE without an idle gap.
    run_frame(0, -1, -1, -1, -1);
    chk("row0_new_snap", ro[0], 0);
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_valid", pif.valid, 0);
    chk("done_count_2", fd_cnt, 2);

    // Reset mid-frame at pixel 500.
    ri[0] = 40'h3;
    frame_req = 1;
    run_frame(0, 500, -1, -1, -1);
    repeat (3) @(negedge clk);
    chk("abort_no_done", fd_cnt, 2);
    chk("abort_idle_busy", busy, 0);
    rst = 1;
    ri[0] = 40'h7;
    @(negedge clk);
    frame_req = 1;
    // Restarted frame under ~30% back-pressure.
    run_frame(30, -1, -1, -1, -1);
    chk("row0_bp", ro[0], 40'h7);
    repeat (4) @(negedge clk);
    chk("done_count_3", fd_cnt, 3);
    chk("final_valid", pif.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
